mult_seq_booth: RTL and testbench
=================================

Name: mult_seq_booth

Overview:
- Parametrised sequential radix-2 Booth multiplier; successor of the fixed 32-bit multiplier in the ALU/MD path.
- Adds a WIDTH parameter, per-operation signed/unsigned mode, an explicit start/busy/done handshake, and result hold between operations.
- The control unit drives start. It waits on done, then reads Hi/Lo.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits split across Hi/Lo; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request a multiply; sampled only when accepted (see Behaviour)
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
- A  input  WIDTH  multiplicand; captured with start
- B  input  WIDTH  multiplier; captured with start
- busy  output  1  high while computing (RUN)
- done  output  1  one-cycle pulse; Hi/Lo are valid from this cycle
- Hi  output  WIDTH  upper half of product
- Lo  output  WIDTH  lower half of product

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, Hi=0, Lo=0; internal accumulator, multiplier and counter registers cleared. Takes effect mid-operation; the pending result is discarded.
- States:
  - IDLE: start=1 at edge -> RUN.
  - RUN: exactly WIDTH+1 cycles, then -> DONE.
  - DONE: one cycle, then -> IDLE, or -> RUN if start=1 at that edge (back-to-back accept).
- Accept condition: start=1 at a rising edge while state is IDLE or DONE.
- On accept, capture operands extended to WIDTH+1 bits:
  - sign-extended when is_signed=1, zero-extended when is_signed=0.
  - accumulator cleared to 0; Booth guard bit Q-1 cleared to 0; counter loaded with WIDTH+1.
- start while in RUN: ignored, no effect.
- Each RUN edge performs one Booth step on the (WIDTH+1)-bit accumulator:
  - {Q0,Q-1}=10 -> acc -= M; 01 -> acc += M; 00/11 -> no operation.
  - Then arithmetic right shift of {acc,Q,Q-1} by 1; acc MSB is replicated (true arithmetic shift, no bit-30 patch).
  - Counter decrements by 1.
- On the final RUN edge (counter 1->0): Hi/Lo loaded with the low 2*WIDTH bits of {acc,Q}; state -> DONE.
- Timing: accept at edge T -> Hi/Lo updated at edge T+WIDTH+1 -> done=1 during cycle [T+WIDTH+1, T+WIDTH+2).
- busy=1 in RUN only; done=1 in DONE only; the two are never both high.
- Hi/Lo hold the last result through IDLE and the next RUN; they change only on a final RUN edge or on reset.
- Width rules:
  - Signed: full 2*WIDTH-bit two's-complement product, so (-2^(W-1))^2 is exact.
  - Unsigned: full 2*WIDTH-bit unsigned product; the extra extension bit prevents misinterpreting MSB=1 operands.
- Operands A/B/is_signed may change freely after the accept edge without affecting the result.

Optional Feature:
- Macro: MULT_SEQ_OVF_EN
- Defined: extra output port ovf (1 bit), reset 0, updated together with Hi/Lo.
  - Signed mode: ovf=1 when Hi is not all copies of Lo[WIDTH-1].
  - Unsigned mode: ovf=1 when Hi != 0.
  - Meaning: the product does not fit in WIDTH bits.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- WIDTH=32, signed, A=7, B=0xFFFFFFFD (-3) -> at done: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; done exactly 33 cycles after the accept edge, busy high for 33 cycles, ovf=0.
- Unsigned A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; same operands signed -> Hi=0, Lo=1.
- Signed A=B=0x80000000 -> Hi=0x40000000, Lo=0; signed A=B=0x00010000 -> Hi=1, Lo=0, ovf=1.
- Handshake: start pulsed again mid-RUN with different operands -> ignored, first result unchanged. start held high in DONE -> second op accepted, done pulses twice 34 cycles apart, Hi/Lo hold the first result until the second completes.
- reset=0 for one cycle, 10 cycles into RUN -> busy/done/Hi/Lo=0 immediately (asynchronous). A new start afterwards (A=5, B=6 unsigned) -> Hi=0, Lo=30.
- WIDTH=8 instance: signed A=0x80, B=0x7F -> Hi=0xC0, Lo=0x80; done 9 cycles after accept.

Source files
------------

// File: rtl/mult_seq_booth.sv
`default_nettype none
//==============================================================================
// Module      : mult_seq_booth
// Description : Sequential radix-2 Booth multiplier with start/busy/done
//               handshake. One Booth step per clock on a (WIDTH+1)-bit
//               accumulator; the extra bit lets the same datapath handle
//               signed and unsigned operands. The product is held on Hi/Lo
//               until the next multiply completes or reset is asserted.
//
// Parameters  : WIDTH      operand width in bits (2..64)
//
// Ports       : clk        rising-edge clock
//               reset      asynchronous reset, active low
//               start      request a multiply (accepted in IDLE or DONE)
//               is_signed  1 = two's-complement operands, 0 = unsigned
//               A, B       multiplicand / multiplier, captured on accept
//               busy       high while the Booth iteration runs
//               done       one-cycle pulse, Hi/Lo valid from this cycle
//               Hi, Lo     upper / lower half of the 2*WIDTH-bit product
//               ovf        (MULT_SEQ_OVF_EN only) product does not fit in
//                          WIDTH bits
//
// Options     : `define MULT_SEQ_OVF_EN adds the ovf output.
//
// Revision    : 1.0  initial release
//==============================================================================
module mult_seq_booth #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
`ifdef MULT_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Counter must hold WIDTH+1 (one step per extended operand bit).
   localparam int                 c_CNT_W    = $clog2(WIDTH + 2);
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH:0]     acc_q,   acc_d;    // Booth accumulator
   logic [WIDTH:0]     q_q,     q_d;      // multiplier, shifts into product low half
   logic               qm1_q,   qm1_d;    // Booth guard bit Q-1
   logic [WIDTH:0]     m_q,     m_d;      // extended multiplicand
   logic [c_CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0]   hi_q,    hi_d;
   logic [WIDTH-1:0]   lo_q,    lo_d;
`ifdef MULT_SEQ_OVF_EN
   logic               signed_q, signed_d;
   logic               ovf_q,    ovf_d;
`endif

   logic [WIDTH:0]     w_sum;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      w_sum   = acc_q;
`ifdef MULT_SEQ_OVF_EN
      signed_d = signed_q;
      ovf_d    = ovf_q;
`endif
      busy    = (state_q == ST_RUN);
      done    = (state_q == ST_DONE);

      case (state_q)
         ST_RUN: begin
            case ({q_q[0], qm1_q})
               2'b10:   w_sum = acc_q - m_q;
               2'b01:   w_sum = acc_q + m_q;
               default: w_sum = acc_q;
            endcase
            // Arithmetic right shift of {acc, Q, Q-1}.
            acc_d = {w_sum[WIDTH], w_sum[WIDTH:1]};
            q_d   = {w_sum[0], q_q[WIDTH:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q - c_CNT_ONE;
            if (cnt_q == c_CNT_ONE) begin
               state_d = ST_DONE;
               // Low 2*WIDTH bits of the (2*WIDTH+2)-bit {acc, Q} result.
               hi_d = {acc_d[WIDTH-2:0], q_d[WIDTH]};
               lo_d = q_d[WIDTH-1:0];
`ifdef MULT_SEQ_OVF_EN
               if (signed_q)
                  ovf_d = (hi_d != {WIDTH{lo_d[WIDTH-1]}});
               else
                  ovf_d = (hi_d != '0);
`endif
            end
         end
         default: begin
            // IDLE and DONE both accept a new request.
            if (start) begin
               state_d = ST_RUN;
               m_d     = {is_signed & A[WIDTH-1], A};
               q_d     = {is_signed & B[WIDTH-1], B};
               acc_d   = '0;
               qm1_d   = 1'b0;
               cnt_d   = c_CNT_LOAD;
`ifdef MULT_SEQ_OVF_EN
               signed_d = is_signed;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MULT_SEQ_OVF_EN
         signed_q <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MULT_SEQ_OVF_EN
         signed_q <= signed_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign Hi = hi_q;
   assign Lo = lo_q;
`ifdef MULT_SEQ_OVF_EN
   assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_booth.sv
`default_nettype none
//==============================================================================
// Module      : tb_mult_seq_booth
// Description : Scoreboard bench for mult_seq_booth (WIDTH=32 and WIDTH=8).
//               Expected products come from a behavioural multiply model and
//               are queued at the accept edge, then popped on done.
// Revision    : 1.0  initial release
//==============================================================================
module tb_mult_seq_booth;

   logic        clk;
   logic        reset;
   logic        start, is_signed;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] Hi, Lo;
   logic        start8, sgn8;
   logic [7:0]  A8, B8;
   logic        busy8, done8;
   logic [7:0]  Hi8, Lo8;
`ifdef MULT_SEQ_OVF_EN
   logic        ovf, ovf8;
`endif

   mult_seq_booth #(.WIDTH(32)) u_dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .A(A), .B(B), .busy(busy), .done(done), .Hi(Hi), .Lo(Lo)
`ifdef MULT_SEQ_OVF_EN
      , .ovf(ovf)
`endif
   );

   mult_seq_booth #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
      .A(A8), .B(B8), .busy(busy8), .done(done8), .Hi(Hi8), .Lo(Lo8)
`ifdef MULT_SEQ_OVF_EN
      , .ovf(ovf8)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] prod;
      logic        ovf;
      int          t;
   } sb_t;

   sb_t         sb[$];
   sb_t         q8[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          run_len = 0;
   logic [63:0] held    = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic sb_t model32(input logic [31:0] a, input logic [31:0] b, input logic s, input int t);
      sb_t    e;
      longint sa, sb_v;
      sa     = s ? longint'($signed(a)) : longint'({32'b0, a});
      sb_v   = s ? longint'($signed(b)) : longint'({32'b0, b});
      e.prod = 64'(sa * sb_v);
      e.ovf  = s ? (e.prod[63:32] != {32{e.prod[31]}}) : (e.prod[63:32] != 32'd0);
      e.t    = t;
      return e;
   endfunction

   function automatic sb_t model8(input logic [7:0] a, input logic [7:0] b, input logic s, input int t);
      sb_t e;
      int  sa, sb_v, p;
      sa     = s ? int'($signed(a)) : int'({24'b0, a});
      sb_v   = s ? int'($signed(b)) : int'({24'b0, b});
      p      = sa * sb_v;
      e.prod = {48'b0, p[15:0]};
      e.ovf  = s ? (p[15:8] != {8{p[7]}}) : (p[15:8] != 8'd0);
      e.t    = t;
      return e;
   endfunction

   // Result monitor for the 32-bit instance.
   always @(posedge clk) begin
      sb_t e;
      #1;
      if (reset === 1'b0) begin
         run_len = 0;
      end else begin
         if (busy === 1'b1) run_len++;
         if (done === 1'b1) begin
            check_eq("busy_at_done", {63'b0, busy}, 64'd0);
            check_eq("sb_nonempty", {63'b0, (sb.size() > 0)}, 64'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check_eq("Hi", {32'b0, Hi}, {32'b0, e.prod[63:32]});
               check_eq("Lo", {32'b0, Lo}, {32'b0, e.prod[31:0]});
               check_eq("latency", 64'(cyc - e.t), 64'd33);
               check_eq("busy_len", 64'(run_len), 64'd33);
`ifdef MULT_SEQ_OVF_EN
               check_eq("ovf", {63'b0, ovf}, {63'b0, e.ovf});
`endif
               held = e.prod;
            end
            run_len = 0;
         end else begin
            check_eq("hold", {Hi, Lo}, held);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request; the edge after the inputs are set is the accept edge.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      int g = 0;
      while (busy === 1'b1 && g < 200) begin
         tick();
         g++;
      end
      A = a; B = b; is_signed = s; start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model32(a, b, s, cyc));
      start     = 1'b0;
      A         = $urandom;
      B         = $urandom;
      is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int g = 0;
      while (sb.size() != 0 && g < 200) begin
         tick();
         g++;
      end
      check_eq("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      sb_t e8;
      int  g;
      int  t8;
      reset = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
      start8 = 1'b0; sgn8 = 1'b0; A8 = '0; B8 = '0;
      repeat (2) tick();
      check_eq("rst_busy", {63'b0, busy}, 64'd0);
      check_eq("rst_done", {63'b0, done}, 64'd0);
      check_eq("rst_HiLo", {Hi, Lo}, 64'd0);
      check_eq("rst_HiLo8", {48'b0, Hi8, Lo8}, 64'd0);
      #2 reset = 1'b1;
      tick();

      do_op(32'd7, 32'hFFFF_FFFD, 1'b1);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
      do_op(32'h0001_0000, 32'h0001_0000, 1'b1);
      wait_idle();

      // start pulsed mid-RUN with other operands must be ignored
      do_op(32'd3, 32'd4, 1'b0);
      repeat (5) tick();
      A = 32'd100; B = 32'd200; start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();

      // start held high through RUN into DONE -> back-to-back accept
      do_op(32'd123456789, 32'd987654321, 1'b0);
      repeat (3) tick();
      A = 32'hFFFF_FFFB; B = 32'd1000; is_signed = 1'b1; start = 1'b1;
      do_op(32'hFFFF_FFFB, 32'd1000, 1'b1);
      wait_idle();

      // asynchronous reset 10 cycles into RUN
      do_op(32'd9, 32'd9, 1'b0);
      repeat (10) tick();
      #2 reset = 1'b0;
      #1;
      check_eq("arst_busy", {63'b0, busy}, 64'd0);
      check_eq("arst_done", {63'b0, done}, 64'd0);
      check_eq("arst_HiLo", {Hi, Lo}, 64'd0);
      sb.delete();
      held = '0;
      @(posedge clk);
      #2 reset = 1'b1;
      tick();
      do_op(32'd5, 32'd6, 1'b0);
      for (int i = 0; i < 4; i++)
         do_op($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_idle();

      // WIDTH=8 instance
      A8 = 8'h80; B8 = 8'h7F; sgn8 = 1'b1; start8 = 1'b1;
      @(posedge clk);
      #1;
      t8 = cyc;
      q8.push_back(model8(8'h80, 8'h7F, 1'b1, t8));
      start8 = 1'b0; A8 = 8'h00; B8 = 8'h00; sgn8 = 1'b0;
      g = 0;
      while (done8 !== 1'b1 && g < 50) begin
         tick();
         g++;
      end
      e8 = q8.pop_front();
      check_eq("w8_latency", 64'(cyc - e8.t), 64'd9);
      check_eq("w8_Hi", {56'b0, Hi8}, {56'b0, e8.prod[15:8]});
      check_eq("w8_Lo", {56'b0, Lo8}, {56'b0, e8.prod[7:0]});
`ifdef MULT_SEQ_OVF_EN
      check_eq("w8_ovf", {63'b0, ovf8}, {63'b0, e8.ovf});
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
